// File: rtl/if_id_stage_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register and its immediate generator.
// Opcodes, bubble encoding, skid FSM states and a saturating increment helper.
package if_id_stage_reg_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_stage_reg_imm_gen.sv
// Combinational RV immediate generator: instruction in, sign-extended immediate out.
// Shared by the IF/ID register and, later, the decode stage.
module imm_gen
   import if_id_stage_reg_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [6:0] opcode;
   logic       sgn;

   assign opcode = instr[6:0];
   assign sgn    = instr[31];

   always_comb begin
      imm = '0;
      unique case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            imm = {{(XLEN-12){sgn}}, instr[31:20]};
         OP_STORE:
            imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm = {{(XLEN-13){sgn}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {{(XLEN-32){sgn}}, instr[31:12], 12'b0};
         OP_JAL:
            imm = {{(XLEN-21){sgn}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with two-entry skid buffer and branch flush.
// Define IF_ID_PERF_CNT_EN to add stall_cycles / flush_count counters.
module if_id_stage_reg
   import if_id_stage_reg_pkg::*;
#(
   parameter int          XLEN      = 64,
   parameter int          ILEN      = 32,
   parameter logic [31:0] NOP_INSTR = if_id_stage_reg_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [ILEN-1:0] in_instr,
   input  logic            flush,
   input  logic            stall,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [6:0]      out_opcode,
   output logic [XLEN-1:0] out_imm
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [31:0]     flush_count
`endif
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] main_pc_q, main_pc_d;
   logic [ILEN-1:0] main_instr_q, main_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [ILEN-1:0] skid_instr_q, skid_instr_d;
   logic            in_ready_q, in_ready_d;

   logic accept;
   logic drain_ok;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid && in_ready_q;
   assign drain_ok  = out_valid && out_ready && !stall;

   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (flush) begin
         state_d      = EMPTY;
         main_instr_d = NOP_INSTR;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d      = FULL;
                  main_pc_d    = in_pc;
                  main_instr_d = in_instr;
               end
            end
            FULL: begin
               if (accept && drain_ok) begin
                  main_pc_d    = in_pc;
                  main_instr_d = in_instr;
               end else if (accept) begin
                  state_d      = SKID;
                  skid_pc_d    = in_pc;
                  skid_instr_d = in_instr;
               end else if (drain_ok) begin
                  state_d      = EMPTY;
                  main_instr_d = NOP_INSTR;
               end
            end
            SKID: begin
               if (drain_ok) begin
                  state_d      = FULL;
                  main_pc_d    = skid_pc_q;
                  main_instr_d = skid_instr_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      // Registered ready: only a held skid entry blocks fetch.
      in_ready_d = (state_d != SKID);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         in_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign out_pc     = main_pc_q;
   assign out_instr  = out_valid ? main_instr_q : NOP_INSTR;
   assign out_opcode = out_instr[6:0];
   assign out_rd     = out_instr[11:7];
   assign out_rs1    = out_instr[19:15];
   assign out_rs2    = out_instr[24:20];

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr (out_instr[31:0]),
      .imm   (out_imm)
   );

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && stall) stall_cnt_d = sat_inc(stall_cnt_q);
      if (flush)              flush_cnt_d = sat_inc(flush_cnt_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed self-checking bench for if_id_stage_reg.
// Counter checks compile in when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_instr;
   logic        flush;
   logic        stall;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [6:0]  out_opcode;
   logic [63:0] out_imm;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_id_stage_reg dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_instr   (in_instr),
      .flush      (flush),
      .stall      (stall),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_rd     (out_rd),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_opcode (out_opcode),
      .out_imm    (out_imm)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] imm_instr [7];
   logic [63:0] imm_exp   [7];

   initial begin
      imm_instr[0] = 32'hFE000EE3; imm_exp[0] = 64'hFFFF_FFFF_FFFF_FFFC;
      imm_instr[1] = 32'h123450B7; imm_exp[1] = 64'h0000_0000_1234_5000;
      imm_instr[2] = 32'hFE112C23; imm_exp[2] = 64'hFFFF_FFFF_FFFF_FFF8;
      imm_instr[3] = 32'h008000EF; imm_exp[3] = 64'h0000_0000_0000_0008;
      imm_instr[4] = 32'hFFFFF097; imm_exp[4] = 64'hFFFF_FFFF_FFFF_F000;
      imm_instr[5] = 32'h002081B3; imm_exp[5] = 64'h0;
      imm_instr[6] = 32'h00432283; imm_exp[6] = 64'h4;

      reset     = 1'b1;
      in_valid  = 1'b1;
      in_pc     = 64'h99;
      in_instr  = 32'h00500093;
      flush     = 1'b0;
      stall     = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_instr", {32'd0, out_instr}, {32'd0, NOP});
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_imm", out_imm, 64'd0);
`ifdef IF_ID_PERF_CNT_EN
      chk("rst_scnt", {32'd0, stall_cycles}, 64'd0);
      chk("rst_fcnt", {32'd0, flush_count}, 64'd0);
`endif

      // first beat after reset release
      reset    = 1'b0;
      in_pc    = 64'h10;
      in_instr = 32'hFFF00093;
      out_ready = 1'b0;
      tick();
      chk("b0_valid", {63'd0, out_valid}, 64'd1);
      chk("b0_pc", out_pc, 64'h10);
      chk("b0_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("b0_rd", {59'd0, out_rd}, 64'd1);
      chk("b0_op", {57'd0, out_opcode}, 64'h13);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("b0_drain", {63'd0, out_valid}, 64'd0);
      chk("b0_nop", {32'd0, out_instr}, {32'd0, NOP});
      chk("b0_pckeep", out_pc, 64'h10);

      // back-to-back stream
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_pc    = 64'(4 * i);
         in_instr = 32'h00000013 | (32'(i + 1) << 7);
         tick();
         chk("st_valid", {63'd0, out_valid}, 64'd1);
         chk("st_pc", out_pc, 64'(4 * i));
         chk("st_rd", {59'd0, out_rd}, 64'(i + 1));
         chk("st_ready", {63'd0, in_ready}, 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("st_end", {63'd0, out_valid}, 64'd0);

      // back-pressure into skid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 64'h20;
      in_instr  = 32'h00100093;
      tick();
      chk("sk_full_rdy", {63'd0, in_ready}, 64'd1);
      in_pc    = 64'h24;
      in_instr = 32'h00200113;
      tick();
      chk("sk_rdy0", {63'd0, in_ready}, 64'd0);
      chk("sk_pc0", out_pc, 64'h20);
      in_pc    = 64'h28;
      in_instr = 32'h00300193;
      tick();
      chk("sk_hold_rdy", {63'd0, in_ready}, 64'd0);
      chk("sk_hold_pc", out_pc, 64'h20);
      chk("sk_hold_rd", {59'd0, out_rd}, 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("sk_pc1", out_pc, 64'h24);
      chk("sk_v1", {63'd0, out_valid}, 64'd1);
      chk("sk_rd1", {59'd0, out_rd}, 64'd2);
      chk("sk_rdy1", {63'd0, in_ready}, 64'd1);
      tick();
      chk("sk_empty", {63'd0, out_valid}, 64'd0);

      // stall blocks drain
      in_valid = 1'b1;
      in_pc    = 64'h30;
      in_instr = 32'h00400213;
      tick();
      in_valid = 1'b0;
      stall    = 1'b1;
      tick();
      chk("stl_valid", {63'd0, out_valid}, 64'd1);
      chk("stl_pc", out_pc, 64'h30);
      stall = 1'b0;
      tick();
      chk("stl_rel", {63'd0, out_valid}, 64'd0);

      // flush while in SKID with fetch pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 64'h40;
      in_instr  = 32'h00100093;
      tick();
      in_pc = 64'h44;
      tick();
      chk("fl_skid", {63'd0, in_ready}, 64'd0);
      flush = 1'b1;
      in_pc = 64'h48;
      tick();
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_nop", {32'd0, out_instr}, {32'd0, NOP});
      chk("fl_rdy", {63'd0, in_ready}, 64'd1);
      chk("fl_pc", out_pc, 64'h40);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("fl_after", {63'd0, out_valid}, 64'd0);

      // flush discards a beat accepted in the same cycle; wins over stall
      in_valid = 1'b1;
      in_pc    = 64'h50;
      in_instr = 32'h00500293;
      tick();
      flush = 1'b1;
      stall = 1'b1;
      in_pc = 64'h54;
      tick();
      chk("fa_valid", {63'd0, out_valid}, 64'd0);
      chk("fa_pc", out_pc, 64'h50);
      flush    = 1'b0;
      stall    = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("fa_after", {63'd0, out_valid}, 64'd0);

      // immediate table, streamed
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_pc    = 64'(16'h100 + 4 * i);
         in_instr = imm_instr[i];
         tick();
         chk("imm", out_imm, imm_exp[i]);
      end
      chk("imm_rd", {59'd0, out_rd}, 64'd5);
      chk("imm_rs1", {59'd0, out_rs1}, 64'd6);
      chk("imm_rs2", {59'd0, out_rs2}, 64'd4);
      in_valid = 1'b0;
      tick();

      // asynchronous reset between edges
      in_valid = 1'b1;
      in_pc    = 64'h80;
      in_instr = 32'h00100093;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_pc", out_pc, 64'd0);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      tick();

`ifdef IF_ID_PERF_CNT_EN
      in_valid = 1'b1;
      in_pc    = 64'h70;
      tick();
      in_valid = 1'b0;
      stall    = 1'b1;
      repeat (5) tick();
      stall = 1'b0;
      flush = 1'b1;
      repeat (2) tick();
      flush = 1'b0;
      chk("pc_stall", {32'd0, stall_cycles}, 64'd5);
      chk("pc_flush", {32'd0, flush_count}, 64'd2);
      #1 reset = 1'b1;
      #1;
      chk("pc_rst_s", {32'd0, stall_cycles}, 64'd0);
      chk("pc_rst_f", {32'd0, flush_count}, 64'd0);
      #1 reset = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
